leg_lite_single: RTL and testbench

Single-cycle 16-bit LEGLite CPU core: program counter, 8×16 register file, ALU, main decoder and branch logic. It fetches one instruction per clock from an external combinational instruction ROM (`IM2`) and accesses an external data memory / memory-mapped I/O block (`DMemory_IO`) through address, data and read/write-enable ports. The top-level wrapper wires the CPU to both blocks. Only the CPU is specified here.

---
 rtl/leg_lite_single.sv | 130 +++++++++++++
 tb/tb_leg_lite_single.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/leg_lite_single.sv
// Single-cycle 16-bit LEGLite core: PC, 8x16 register file (X7 = XZR), ALU, decoder, branch logic.
// Instruction and data memories are external and combinational on the read side.
module leg_lite_single (
  output logic [15:0] iaddr,
  output logic [15:0] draddr,
  output logic        dwrite,
  output logic        dread,
  output logic [15:0] dwdata,
  output logic [15:0] alu_out,
  input  logic        clock,
  input  logic [15:0] idata,
  input  logic [15:0] drdata,
  input  logic        reset
);

  typedef enum logic [2:0] {
    OpR    = 3'b000,
    OpNop  = 3'b001,
    OpB    = 3'b010,
    OpLd   = 3'b011,
    OpSt   = 3'b100,
    OpAddi = 3'b101,
    OpAndi = 3'b110,
    OpCbz  = 3'b111
  } opcode_e;

  opcode_e     opcode;
  logic [2:0]  rn_idx;
  logic [2:0]  rm_idx;
  logic [3:0]  funct;
  logic [15:0] rn_val;
  logic [15:0] rm_val;
  logic [15:0] imm_sext;
  logic [15:0] imm_zext;
  logic [15:0] off_b;
  logic [15:0] off_cbz;

  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic [15:0] regs_q [7];

  logic        reg_we;
  logic [2:0]  wr_idx;
  logic [15:0] wr_data;

  assign opcode   = opcode_e'(idata[15:13]);
  assign rn_idx   = idata[12:10];
  assign rm_idx   = idata[9:7];
  assign funct    = idata[3:0];
  assign imm_sext = {{9{idata[6]}}, idata[6:0]};
  assign imm_zext = {9'b0, idata[6:0]};
  assign off_b    = {{2{idata[12]}}, idata[12:0], 1'b0};
  assign off_cbz  = {{5{idata[9]}}, idata[9:0], 1'b0};

  // X7 has no storage; it reads as zero.
  assign rn_val = (rn_idx == 3'd7) ? 16'h0000 : regs_q[rn_idx];
  assign rm_val = (rm_idx == 3'd7) ? 16'h0000 : regs_q[rm_idx];

  always_comb begin
    alu_out = rn_val;
    unique case (opcode)
      OpR: begin
        case (funct)
          4'd0:    alu_out = rn_val + rm_val;
          4'd1:    alu_out = rn_val - rm_val;
          4'd2:    alu_out = rn_val & rm_val;
          4'd3:    alu_out = rn_val | rm_val;
          default: alu_out = rn_val + rm_val;
        endcase
      end
      OpLd, OpSt, OpAddi: alu_out = rn_val + imm_sext;
      OpAndi:             alu_out = rn_val & imm_zext;
      // CBZ passes Rt (field [12:10]) so zero detect can look at alu_out.
      default:            alu_out = rn_val;
    endcase
  end

  always_comb begin
    reg_we  = 1'b0;
    wr_idx  = idata[9:7];
    wr_data = alu_out;
    unique case (opcode)
      OpR: begin
        reg_we = (funct[3:2] == 2'b00);
        wr_idx = idata[6:4];
      end
      OpLd: begin
        reg_we  = 1'b1;
        wr_data = drdata;
      end
      OpAddi, OpAndi: reg_we = 1'b1;
      default:        reg_we = 1'b0;
    endcase
    if (wr_idx == 3'd7) begin
      reg_we = 1'b0;
    end
  end

  always_comb begin
    pc_d = pc_q + 16'd2;
    unique case (opcode)
      OpB:     pc_d = pc_q + off_b;
      OpCbz:   pc_d = (alu_out == 16'h0000) ? pc_q + off_cbz : pc_q + 16'd2;
      default: pc_d = pc_q + 16'd2;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= 16'h0000;
      for (int i = 0; i < 7; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else begin
      pc_q <= pc_d;
      for (int i = 0; i < 7; i++) begin
        if (reg_we && (wr_idx == 3'(i))) begin
          regs_q[i] <= wr_data;
        end
      end
    end
  end

  assign iaddr  = pc_q;
  assign draddr = alu_out;
  assign dwdata = rm_val;
  assign dread  = (opcode == OpLd);
  assign dwrite = (opcode == OpSt);

endmodule

// File: tb/tb_leg_lite_single.sv
// Directed bench for leg_lite_single; instructions are driven per cycle, data memory and
// a small I/O block (switch at 0xFFF0, 7-segment latch at 0xFFF2) are modelled here.
module tb_leg_lite_single;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] idata;
  logic [15:0] drdata;
  logic [15:0] iaddr;
  logic [15:0] draddr;
  logic        dwrite;
  logic        dread;
  logic [15:0] dwdata;
  logic [15:0] alu_out;

  logic [15:0] mem [128];
  logic [6:0]  seg7;
  logic        io_sw0 = 1'b0;

  int tests = 0;
  int fails = 0;

  localparam logic [15:0] Nop = 16'h2000;

  leg_lite_single dut (
    .iaddr  (iaddr),
    .draddr (draddr),
    .dwrite (dwrite),
    .dread  (dread),
    .dwdata (dwdata),
    .alu_out(alu_out),
    .clock  (clock),
    .idata  (idata),
    .drdata (drdata),
    .reset  (reset)
  );

  always #5 clock = ~clock;

  always_comb begin
    if (draddr == 16'hFFF0)      drdata = {15'b0, io_sw0};
    else if (draddr == 16'hFFF2) drdata = {9'b0, seg7};
    else                         drdata = mem[draddr[7:1]];
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      seg7 <= 7'h00;
      for (int i = 0; i < 128; i++) mem[i] <= 16'h0000;
    end else if (dwrite) begin
      if (draddr == 16'hFFF2)           seg7 <= dwdata[6:0];
      else if (draddr[15:8] == 8'h00)   mem[draddr[7:1]] <= dwdata;
    end
  end

  function automatic logic [15:0] f_r(input logic [2:0] rn, input logic [2:0] rm,
                                      input logic [2:0] rd, input logic [3:0] fn);
    return {3'b000, rn, rm, rd, fn};
  endfunction

  function automatic logic [15:0] f_i(input logic [2:0] op, input logic [2:0] rn,
                                      input logic [2:0] rt, input logic [6:0] imm);
    return {op, rn, rt, imm};
  endfunction

  function automatic logic [15:0] f_cbz(input logic [2:0] rt, input logic [9:0] off);
    return {3'b111, rt, off};
  endfunction

  function automatic logic [15:0] f_b(input logic [12:0] off);
    return {3'b010, off};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input logic [15:0] instr);
    idata = instr;
    #1;
  endtask

  // A NOP whose [9:7] field selects the register shown on dwdata.
  task automatic read_reg(input logic [2:0] idx, output logic [15:0] v);
    idata = {3'b001, 3'b000, idx, 7'b0};
    #1;
    v = dwdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idata = Nop;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b1;
    idata = 16'h0000;
    #1;
    tests++; if (iaddr !== 16'h0000) begin fails++; $display("FAIL reset_iaddr got %h want 0000", iaddr); end
    tests++; if (dwrite !== 1'b0) begin fails++; $display("FAIL reset_dwrite got %b want 0", dwrite); end
    tests++; if (dread !== 1'b0) begin fails++; $display("FAIL reset_dread got %b want 0", dread); end
    apply(f_i(3'b101, 3'd7, 3'd1, 7'd5));
    tick();
    tick();
    tests++; if (iaddr !== 16'h0000) begin fails++; $display("FAIL reset_hold_pc got %h want 0000", iaddr); end
    read_reg(3'd1, v);
    tests++; if (v !== 16'h0000) begin fails++; $display("FAIL reset_hold_reg got %h want 0000", v); end
    reset = 1'b0;
    // Load two registers, then run up to PC=0x0010 and pulse reset between edges.
    apply(f_i(3'b101, 3'd7, 3'd1, 7'd5)); tick();
    apply(f_i(3'b101, 3'd7, 3'd6, 7'd9)); tick();
    apply(Nop);
    for (int i = 0; i < 6; i++) tick();
    tests++; if (iaddr !== 16'h0010) begin fails++; $display("FAIL run_to_10 got %h want 0010", iaddr); end
    read_reg(3'd1, v);
    tests++; if (v !== 16'h0005) begin fails++; $display("FAIL pre_reset_x1 got %h want 0005", v); end
    reset = 1'b1;
    #1;
    tests++; if (iaddr !== 16'h0000) begin fails++; $display("FAIL midrun_iaddr got %h want 0000", iaddr); end
    #1;
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      read_reg(3'(i), v);
      tests++; if (v !== 16'h0000) begin fails++; $display("FAIL midrun_x%0d got %h want 0000", i, v); end
    end
    tick();
  endtask

  task automatic test_arith();
    logic [15:0] v;
    do_reset();
    apply(f_i(3'b101, 3'd7, 3'd1, 7'd5));
    tests++; if (alu_out !== 16'h0005) begin fails++; $display("FAIL addi_alu got %h want 0005", alu_out); end
    tick();
    apply(f_i(3'b101, 3'd7, 3'd2, 7'h7D));
    tests++; if (alu_out !== 16'hFFFD) begin fails++; $display("FAIL addi_neg_alu got %h want fffd", alu_out); end
    tick();
    apply(f_r(3'd1, 3'd2, 3'd3, 4'd0));
    tests++; if (alu_out !== 16'h0002) begin fails++; $display("FAIL add_alu got %h want 0002", alu_out); end
    tick();
    apply(f_r(3'd1, 3'd2, 3'd4, 4'd1));
    tests++; if (alu_out !== 16'h0008) begin fails++; $display("FAIL sub_alu got %h want 0008", alu_out); end
    tick();
    read_reg(3'd3, v);
    tests++; if (v !== 16'h0002) begin fails++; $display("FAIL add_x3 got %h want 0002", v); end
    read_reg(3'd4, v);
    tests++; if (v !== 16'h0008) begin fails++; $display("FAIL sub_x4 got %h want 0008", v); end
    apply(f_r(3'd1, 3'd2, 3'd5, 4'd2));
    tests++; if (alu_out !== 16'h0005) begin fails++; $display("FAIL and_alu got %h want 0005", alu_out); end
    apply(f_r(3'd1, 3'd2, 3'd5, 4'd3));
    tests++; if (alu_out !== 16'hFFFD) begin fails++; $display("FAIL orr_alu got %h want fffd", alu_out); end
    apply(f_i(3'b110, 3'd2, 3'd5, 7'h7F));
    tests++; if (alu_out !== 16'h007D) begin fails++; $display("FAIL andi_alu got %h want 007d", alu_out); end
    tick();
    read_reg(3'd5, v);
    tests++; if (v !== 16'h007D) begin fails++; $display("FAIL andi_x5 got %h want 007d", v); end
    // Writes to XZR and undefined functs must not change state.
    apply(f_i(3'b101, 3'd7, 3'd7, 7'd1)); tick();
    read_reg(3'd7, v);
    tests++; if (v !== 16'h0000) begin fails++; $display("FAIL xzr_write got %h want 0000", v); end
    apply(f_r(3'd1, 3'd1, 3'd3, 4'd4)); tick();
    read_reg(3'd3, v);
    tests++; if (v !== 16'h0002) begin fails++; $display("FAIL bad_funct_x3 got %h want 0002", v); end
    // Same-cycle write/read of X1: read sees the old value.
    apply(f_i(3'b101, 3'd1, 3'd1, 7'd1));
    tests++; if (dwdata !== 16'h0005) begin fails++; $display("FAIL same_cycle_old got %h want 0005", dwdata); end
    tick();
    read_reg(3'd1, v);
    tests++; if (v !== 16'h0006) begin fails++; $display("FAIL same_cycle_new got %h want 0006", v); end
  endtask

  task automatic test_mem();
    logic [15:0] v;
    do_reset();
    apply(f_i(3'b101, 3'd7, 3'd1, 7'd7)); tick();
    apply(f_i(3'b100, 3'd7, 3'd1, 7'd4));
    tests++; if (draddr !== 16'h0004) begin fails++; $display("FAIL st_draddr got %h want 0004", draddr); end
    tests++; if (dwdata !== 16'h0007) begin fails++; $display("FAIL st_dwdata got %h want 0007", dwdata); end
    tests++; if ({dwrite, dread} !== 2'b10) begin fails++; $display("FAIL st_we_re got %b want 10", {dwrite, dread}); end
    tick();
    apply(f_i(3'b011, 3'd7, 3'd2, 7'd4));
    tests++; if ({dwrite, dread} !== 2'b01) begin fails++; $display("FAIL ld_we_re got %b want 01", {dwrite, dread}); end
    tick();
    apply(f_r(3'd2, 3'd7, 3'd3, 4'd0));
    tests++; if (alu_out !== 16'h0007) begin fails++; $display("FAIL ld_use_alu got %h want 0007", alu_out); end
    read_reg(3'd2, v);
    tests++; if (v !== 16'h0007) begin fails++; $display("FAIL ld_x2 got %h want 0007", v); end
  endtask

  task automatic test_cbz();
    do_reset();
    apply(Nop); tick(); tick();
    apply(f_cbz(3'd7, 10'd3));
    tests++; if (alu_out !== 16'h0000) begin fails++; $display("FAIL cbz_alu_zero got %h want 0000", alu_out); end
    tick();
    tests++; if (iaddr !== 16'h000A) begin fails++; $display("FAIL cbz_taken got %h want 000a", iaddr); end
    apply(f_cbz(3'd7, 10'h3FE)); tick();
    tests++; if (iaddr !== 16'h0006) begin fails++; $display("FAIL cbz_back got %h want 0006", iaddr); end
    do_reset();
    apply(f_i(3'b101, 3'd7, 3'd1, 7'd1)); tick();
    apply(Nop); tick();
    tests++; if (iaddr !== 16'h0004) begin fails++; $display("FAIL cbz_setup got %h want 0004", iaddr); end
    apply(f_cbz(3'd1, 10'd3));
    tests++; if (alu_out !== 16'h0001) begin fails++; $display("FAIL cbz_alu_rt got %h want 0001", alu_out); end
    tick();
    tests++; if (iaddr !== 16'h0006) begin fails++; $display("FAIL cbz_not_taken got %h want 0006", iaddr); end
  endtask

  task automatic test_branch();
    do_reset();
    apply(Nop);
    for (int i = 0; i < 4; i++) tick();
    apply(f_b(13'd0));
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++; if (iaddr !== 16'h0008) begin fails++; $display("FAIL b_self_loop cyc%0d got %h want 0008", i, iaddr); end
    end
    apply(f_b(13'h1FFC)); tick();
    tests++; if (iaddr !== 16'h0000) begin fails++; $display("FAIL b_back got %h want 0000", iaddr); end
    apply(f_b(13'd5)); tick();
    tests++; if (iaddr !== 16'h000A) begin fails++; $display("FAIL b_fwd got %h want 000a", iaddr); end
  endtask

  task automatic test_io();
    logic [15:0] v;
    do_reset();
    apply(f_i(3'b101, 3'd7, 3'd5, 7'h70)); tick();
    io_sw0 = 1'b1;
    apply(f_i(3'b011, 3'd5, 3'd1, 7'd0));
    tests++; if (draddr !== 16'hFFF0) begin fails++; $display("FAIL sw_draddr got %h want fff0", draddr); end
    tick();
    read_reg(3'd1, v);
    tests++; if (v !== 16'h0001) begin fails++; $display("FAIL sw_on got %h want 0001", v); end
    io_sw0 = 1'b0;
    apply(f_i(3'b011, 3'd5, 3'd1, 7'd0)); tick();
    read_reg(3'd1, v);
    tests++; if (v !== 16'h0000) begin fails++; $display("FAIL sw_off got %h want 0000", v); end
    apply(f_i(3'b101, 3'd7, 3'd2, 7'h3F)); tick();
    apply(f_i(3'b100, 3'd5, 3'd2, 7'd2));
    tests++; if (draddr !== 16'hFFF2) begin fails++; $display("FAIL seg_draddr got %h want fff2", draddr); end
    tick();
    tests++; if (seg7 !== 7'h3F) begin fails++; $display("FAIL seg_pattern got %h want 3f", seg7); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mem();
    test_cbz();
    test_branch();
    test_io();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
